tmr_div_slice: RTL and testbench
================================

Name: tmr_div_slice

Overview:
- One slice of a triplicated programmable clock divider. Three instances sit side by side in the TMR wrapper, with their `divNext` outputs cross-connected to every slice's `divNextA`/`divNextB`/`divNextC` inputs.
- Each slice majority-votes the three next-state words, registers the result as its counter and derives a divided clock and a period tick.
- It extends the fixed divide-by-4 slice with a parametrised width, a runtime divide ratio, an enable and voter-mismatch monitoring.

Parameters:
- `WIDTH`, 8: counter and ratio width in bits; divide ratio range 2..2^WIDTH-1.
- `ERR_CNT_WIDTH`, 4: width of the saturating mismatch counter.

Ports:
- `clkIn`  input  1  slice clock; all state is on the rising edge.
- `rstIn`  input  1  synchronous reset, active high.
- `enIn`  input  1  count enable.
- `ratioIn`  input  `WIDTH`  divide ratio N; sampled only at reload.
- `divNext`  output  `WIDTH`  unvoted next counter value from this slice (combinational).
- `divNextA`  input  `WIDTH`  next-state word from slice A.
- `divNextB`  input  `WIDTH`  next-state word from slice B.
- `divNextC`  input  `WIDTH`  next-state word from slice C.
- `clkOut`  output  1  divided clock (registered).
- `tickOut`  output  1  one-cycle pulse at each period start (registered).
- `errClrIn`  input  1  clears `errCntOut`.
- `errOut`  output  1  voter-disagreement flag (registered).
- `errCntOut`  output  `ERR_CNT_WIDTH`  saturating mismatch count.

Behaviour:
- **Clock and reset:** single clock `clkIn`. Reset is synchronous, active high on `rstIn` and overrides everything.
- **Reset values:** `cnt`=0, `ratioReg`=2, `clkOut`=0, `tickOut`=0, `errOut`=0, `errCntOut`=0.
- **Vote:** `voted` = bitwise majority of (`divNextA`, `divNextB`, `divNextC`), combinational. Every non-reset edge: `cnt` <= `voted`. There is no local feedback path bypassing the voter.
- **Effective ratio:** `Neff` = `ratioIn` if `ratioIn` >= 2, else 2.
- **Reload condition:** `reload` = `enIn` && (`cnt` == 0).
- **`divNext` (combinational):**
  - `enIn` = 0: `cnt` (hold).
  - `reload`: `Neff` - 1.
  - otherwise: `cnt` - 1.
  - There is no wrap-around below 0; 0 always reloads.
- **Ratio register:** `ratioReg` <= `Neff` on `reload`, else holds. Ratio changes take effect only at the next reload; a mid-period change never truncates or extends the current period.
- **`clkOut`:** `clkOut` <= (`voted` >= (`ratioNext` >> 1)), where `ratioNext` = `reload` ? `Neff` : `ratioReg`.
  - Even N: 50% duty.
  - Odd N: high for ceil(N/2) cycles.
  - Rising edge coincides with the reload edge.
- **`tickOut`:** `tickOut` <= `reload`. This includes the first reload after reset (first edge with `enIn`=1).
- **Enable low:** `cnt`, `ratioReg` and `clkOut` hold their values; `tickOut`=0. Resume continues from the held count.
- **Mismatch flag:** `mismatch` = (A != B) || (B != C) || (A != C), any bit. `errOut` <= `mismatch`.
- **Mismatch counter:**
  - Clear has priority: `errClrIn`=1 gives `errCntOut` <= 0.
  - Else on `mismatch`, `errCntOut` increments, saturating at all-ones.
  - Simultaneous clear and mismatch yields 0.
- **Single upset:** a corrupted word from one slice is outvoted the same cycle. The counters of all three slices stay identical; only `errOut` and `errCntOut` react.
- **Reset mid-period:** next edge gives `cnt`=0 and `clkOut`=0. If `enIn`=1, a reload follows on the edge after reset deasserts.
- **Latency:** `ratioIn` takes effect at the first reload after it is applied. `clkOut` and `tickOut` are aligned to the `cnt` register (zero extra latency).

Test Plan:
- **Basic divide, N=4:** three slices cross-connected, reset then `enIn`=1 → `cnt` sequence 3,2,1,0 repeating; `clkOut` 1,1,0,0; `tickOut` high on each `cnt`=3 edge; `errOut`=0 throughout.
- **Odd ratio and change at reload:** N=5 → `clkOut` 3 high / 2 low. Change `ratioIn` to 6 at `cnt`=2 → current period completes at 5 cycles; next period is 6 cycles, 3/3 duty.
- **Ratio clamp:** `ratioIn`=0, then 1 → each behaves as N=2; `clkOut` toggles every cycle, `tickOut` every other cycle.
- **Enable gating and reset:**
  - Drop `enIn` at `cnt`=2 for 3 cycles → `cnt`, `clkOut` frozen, `tickOut`=0; resume at 1.
  - Assert `rstIn` mid-period → all outputs 0, `cnt`=0 the next edge.
- **Single-slice upset:** force `divNextB`=8'hFF for 1 cycle → all slices' `cnt` unaffected; `errOut`=1 for 1 cycle; `errCntOut`=1. Repeat 20 times → saturates at 15. `errClrIn` together with a forced mismatch → 0.
- **Width parameter:** `WIDTH`=16, N=1000 → period 1000 cycles, `clkOut` 500/500. N=65535 → no overflow, period 65535.

Source files
------------

// File: rtl/tmr_div_slice.sv
// rtl/tmr_div_slice.sv - one slice of a triplicated programmable clock divider
// The slice votes the three next-state words, registers the counter and derives clkOut, tickOut and mismatch status.
module tmr_div_slice #(
    parameter int WIDTH         = 8,
    parameter int ERR_CNT_WIDTH = 4
) (
    input  logic                     clkIn,
    input  logic                     rstIn,
    input  logic                     enIn,
    input  logic [WIDTH-1:0]         ratioIn,
    output logic [WIDTH-1:0]         divNext,
    input  logic [WIDTH-1:0]         divNextA,
    input  logic [WIDTH-1:0]         divNextB,
    input  logic [WIDTH-1:0]         divNextC,
    output logic                     clkOut,
    output logic                     tickOut,
    input  logic                     errClrIn,
    output logic                     errOut,
    output logic [ERR_CNT_WIDTH-1:0] errCntOut
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] ratio_reg;
    logic [WIDTH-1:0] voted;
    logic [WIDTH-1:0] neff;
    logic [WIDTH-1:0] ratio_next;
    logic             reload;
    logic             mismatch;

    // The counter is only ever loaded from the vote, so a single upset never survives a cycle.
    assign voted      = (divNextA & divNextB) | (divNextB & divNextC) | (divNextA & divNextC);
    assign mismatch   = (divNextA != divNextB) || (divNextB != divNextC) || (divNextA != divNextC);
    assign neff       = (ratioIn >= WIDTH'(2)) ? ratioIn : WIDTH'(2);
    assign reload     = enIn && (cnt == '0);
    assign ratio_next = reload ? neff : ratio_reg;

    always_comb begin
        divNext = cnt;
        if (reload) begin
            divNext = neff - WIDTH'(1);
        end else if (enIn) begin
            divNext = cnt - WIDTH'(1);
        end
    end

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            cnt       <= '0;
            ratio_reg <= WIDTH'(2);
            clkOut    <= 1'b0;
            tickOut   <= 1'b0;
            errOut    <= 1'b0;
            errCntOut <= '0;
        end else begin
            cnt     <= voted;
            tickOut <= reload;
            errOut  <= mismatch;
            if (reload) begin
                ratio_reg <= neff;
            end
            // Duty threshold uses the ratio of the period being entered so the reload edge rises.
            if (enIn) begin
                clkOut <= (voted >= (ratio_next >> 1));
            end
            if (errClrIn) begin
                errCntOut <= '0;
            end else if (mismatch && !(&errCntOut)) begin
                errCntOut <= errCntOut + ERR_CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_tmr_div_slice.sv
// tb/tb_tmr_div_slice.sv - directed bench for three cross-connected slices and a 16-bit slice
module tb_tmr_div_slice;

    logic       clk = 1'b0;
    logic       rst, en, err_clr, force_b;
    logic [7:0] ratio;
    logic [7:0] n_a, n_b, n_c, in_b;
    logic       clk_a, clk_b, clk_c, tick_a, tick_b, tick_c, err_a, err_b, err_c;
    logic [3:0] ecnt_a, ecnt_b, ecnt_c;

    logic        rst16, en16, clk16, tick16, err16;
    logic [15:0] ratio16, n16;
    logic [3:0]  ecnt16;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign in_b = force_b ? 8'hFF : n_b;

    tmr_div_slice #(.WIDTH(8), .ERR_CNT_WIDTH(4)) u_a (
        .clkIn(clk), .rstIn(rst), .enIn(en), .ratioIn(ratio), .divNext(n_a),
        .divNextA(n_a), .divNextB(in_b), .divNextC(n_c), .clkOut(clk_a), .tickOut(tick_a),
        .errClrIn(err_clr), .errOut(err_a), .errCntOut(ecnt_a));
    tmr_div_slice #(.WIDTH(8), .ERR_CNT_WIDTH(4)) u_b (
        .clkIn(clk), .rstIn(rst), .enIn(en), .ratioIn(ratio), .divNext(n_b),
        .divNextA(n_a), .divNextB(in_b), .divNextC(n_c), .clkOut(clk_b), .tickOut(tick_b),
        .errClrIn(err_clr), .errOut(err_b), .errCntOut(ecnt_b));
    tmr_div_slice #(.WIDTH(8), .ERR_CNT_WIDTH(4)) u_c (
        .clkIn(clk), .rstIn(rst), .enIn(en), .ratioIn(ratio), .divNext(n_c),
        .divNextA(n_a), .divNextB(in_b), .divNextC(n_c), .clkOut(clk_c), .tickOut(tick_c),
        .errClrIn(err_clr), .errOut(err_c), .errCntOut(ecnt_c));

    tmr_div_slice #(.WIDTH(16), .ERR_CNT_WIDTH(4)) u_w16 (
        .clkIn(clk), .rstIn(rst16), .enIn(en16), .ratioIn(ratio16), .divNext(n16),
        .divNextA(n16), .divNextB(n16), .divNextC(n16), .clkOut(clk16), .tickOut(tick16),
        .errClrIn(1'b0), .errOut(err16), .errCntOut(ecnt16));

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; err_clr = 1'b0; force_b = 1'b0; ratio = 8'd4;
        rst16 = 1'b1; en16 = 1'b0; ratio16 = 16'd1000;
        repeat (2) @(negedge clk);
        checks++;
        if ({u_a.cnt, u_b.cnt, u_c.cnt} !== 24'h0) begin
            errors++; $display("FAIL reset_cnt got %h %h %h want 00", u_a.cnt, u_b.cnt, u_c.cnt);
        end
        checks++;
        if (u_a.ratio_reg !== 8'd2) begin
            errors++; $display("FAIL reset_ratio got %0d want 2", u_a.ratio_reg);
        end
        checks++;
        if ({clk_a, clk_b, clk_c, tick_a, tick_b, tick_c, err_a, ecnt_a} !== 11'b0) begin
            errors++; $display("FAIL reset_outputs got clk=%b tick=%b err=%b ecnt=%0d want 0",
                               clk_a, tick_a, err_a, ecnt_a);
        end
    endtask

    task automatic test_basic_n4;
        int e_cnt[4] = '{3, 2, 1, 0};
        int e_clk[4] = '{1, 1, 0, 0};
        rst = 1'b0; en = 1'b1; ratio = 8'd4;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (u_a.cnt !== 8'(e_cnt[i%4]) || u_b.cnt !== 8'(e_cnt[i%4]) || u_c.cnt !== 8'(e_cnt[i%4])) begin
                errors++; $display("FAIL n4_cnt[%0d] got %0d %0d %0d want %0d", i, u_a.cnt, u_b.cnt, u_c.cnt, e_cnt[i%4]);
            end
            checks++;
            if (clk_a !== e_clk[i%4][0] || tick_a !== (i%4 == 0) || err_a !== 1'b0 || clk_b !== clk_a || clk_c !== clk_a) begin
                errors++; $display("FAIL n4_out[%0d] got clk=%b tick=%b err=%b want clk=%0d tick=%0d err=0",
                                   i, clk_a, tick_a, err_a, e_clk[i%4], (i%4 == 0));
            end
        end
    endtask

    task automatic test_odd_change;
        int e_cnt[11] = '{4, 3, 2, 1, 0, 5, 4, 3, 2, 1, 0};
        int e_clk[11] = '{1, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0};
        int e_tck[11] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        ratio = 8'd5;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            checks++;
            if (u_a.cnt !== 8'(e_cnt[i]) || clk_a !== e_clk[i][0] || tick_a !== e_tck[i][0]) begin
                errors++; $display("FAIL odd_change[%0d] got cnt=%0d clk=%b tick=%b want cnt=%0d clk=%0d tick=%0d",
                                   i, u_a.cnt, clk_a, tick_a, e_cnt[i], e_clk[i], e_tck[i]);
            end
            if (i == 2) ratio = 8'd6;
        end
    endtask

    task automatic test_clamp;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) ratio = 8'd0;
            if (i == 4) ratio = 8'd1;
            @(negedge clk);
            checks++;
            if (u_a.cnt !== 8'(1 - i%2) || clk_a !== (i%2 == 0) || tick_a !== (i%2 == 0)) begin
                errors++; $display("FAIL clamp[%0d] got cnt=%0d clk=%b tick=%b want cnt=%0d clk=%0d tick=%0d",
                                   i, u_a.cnt, clk_a, tick_a, 1 - i%2, (i%2 == 0), (i%2 == 0));
            end
        end
        checks++;
        if (u_a.ratio_reg !== 8'd2) begin
            errors++; $display("FAIL clamp_ratio got %0d want 2", u_a.ratio_reg);
        end
    endtask

    task automatic test_enable;
        int e_cnt[8] = '{3, 2, 2, 2, 2, 1, 0, 3};
        int e_clk[8] = '{1, 1, 1, 1, 1, 0, 0, 1};
        int e_tck[8] = '{1, 0, 0, 0, 0, 0, 0, 1};
        ratio = 8'd4;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (u_a.cnt !== 8'(e_cnt[i]) || clk_a !== e_clk[i][0] || tick_a !== e_tck[i][0]) begin
                errors++; $display("FAIL enable[%0d] got cnt=%0d clk=%b tick=%b want cnt=%0d clk=%0d tick=%0d",
                                   i, u_a.cnt, clk_a, tick_a, e_cnt[i], e_clk[i], e_tck[i]);
            end
            if (i == 1) en = 1'b0;
            if (i == 4) en = 1'b1;
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (u_a.cnt !== 8'd0 || u_c.cnt !== 8'd0 || clk_a !== 1'b0 || tick_a !== 1'b0) begin
            errors++; $display("FAIL reset_mid got cnt=%0d clk=%b tick=%b want 0 0 0", u_a.cnt, clk_a, tick_a);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (u_a.cnt !== 8'd3 || clk_a !== 1'b1 || tick_a !== 1'b1) begin
            errors++; $display("FAIL reset_reload got cnt=%0d clk=%b tick=%b want 3 1 1", u_a.cnt, clk_a, tick_a);
        end
    endtask

    task automatic test_upset;
        int exp_cnt = 3;
        force_b = 1'b1;
        @(negedge clk);
        exp_cnt = 2;
        checks++;
        if (u_a.cnt !== 8'd2 || u_b.cnt !== 8'd2 || u_c.cnt !== 8'd2 || err_a !== 1'b1 || ecnt_a !== 4'd1 || ecnt_b !== 4'd1) begin
            errors++; $display("FAIL upset_one got cnt=%0d/%0d/%0d err=%b ecnt=%0d want cnt=2 err=1 ecnt=1",
                               u_a.cnt, u_b.cnt, u_c.cnt, err_a, ecnt_a);
        end
        force_b = 1'b0;
        @(negedge clk);
        exp_cnt = 1;
        checks++;
        if (u_b.cnt !== 8'd1 || err_b !== 1'b0 || ecnt_c !== 4'd1) begin
            errors++; $display("FAIL upset_clear got cnt=%0d err=%b ecnt=%0d want 1 0 1", u_b.cnt, err_b, ecnt_c);
        end
        force_b = 1'b1;
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            exp_cnt = (exp_cnt == 0) ? 3 : exp_cnt - 1;
            checks++;
            if (u_a.cnt !== 8'(exp_cnt) || u_b.cnt !== 8'(exp_cnt) || u_c.cnt !== 8'(exp_cnt)) begin
                errors++; $display("FAIL upset_cnt[%0d] got %0d %0d %0d want %0d", i, u_a.cnt, u_b.cnt, u_c.cnt, exp_cnt);
            end
        end
        checks++;
        if (ecnt_a !== 4'd15 || ecnt_b !== 4'd15 || ecnt_c !== 4'd15 || err_a !== 1'b1) begin
            errors++; $display("FAIL upset_sat got ecnt=%0d err=%b want 15 1", ecnt_a, err_a);
        end
        err_clr = 1'b1;
        @(negedge clk);
        checks++;
        if (ecnt_a !== 4'd0 || err_a !== 1'b1) begin
            errors++; $display("FAIL clr_priority got ecnt=%0d err=%b want 0 1", ecnt_a, err_a);
        end
        err_clr = 1'b0; force_b = 1'b0;
        @(negedge clk);
        checks++;
        if (ecnt_a !== 4'd0 || err_a !== 1'b0) begin
            errors++; $display("FAIL clr_after got ecnt=%0d err=%b want 0 0", ecnt_a, err_a);
        end
    endtask

    task automatic measure16(input int n, input int bound);
        int period = 0;
        int high = 0;
        checks++;
        if (u_w16.cnt !== 16'(n - 1)) begin
            errors++; $display("FAIL w16_start n=%0d got cnt=%0d want %0d", n, u_w16.cnt, n - 1);
        end
        do begin
            high += int'(clk16);
            period++;
            @(negedge clk);
        end while (!tick16 && period < bound);
        checks++;
        if (period != n || high != (n + 1) / 2) begin
            errors++; $display("FAIL w16_period n=%0d got period=%0d high=%0d want %0d %0d",
                               n, period, high, n, (n + 1) / 2);
        end
    endtask

    task automatic test_width16;
        int guard = 0;
        rst16 = 1'b0; en16 = 1'b1; ratio16 = 16'd1000;
        @(negedge clk);
        while (!tick16 && guard < 10) begin @(negedge clk); guard++; end
        checks++;
        if (!tick16) begin
            errors++; $display("FAIL w16_first_tick got 0 want 1");
        end
        measure16(1000, 1100);
        ratio16 = 16'd65535;
        measure16(1000, 1100);
        measure16(65535, 66000);
    endtask

    initial begin
        test_reset();
        test_basic_n4();
        test_odd_change();
        test_clamp();
        test_enable();
        test_reset_mid();
        test_upset();
        test_width16();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
